// File: rtl/sine_pkg.sv
// Shared types and constants for the quarter-sine colour layer sequencer.
package sine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } sine_state_t;

    localparam int unsigned SINE_BAND_ROWS = 22;
    localparam logic [4:0]  SINE_Y_BLANK   = 5'd31;
    localparam logic [5:0]  RGB_BLACK      = 6'b000000;

endpackage

// File: rtl/sine_frame_seq.sv
// Frame-level sequencer: run/pause/idle FSM, scroll stepping and day/night toggling.
// Optional reverse scrolling is enabled with SINE_SCROLL_REVERSE_EN.
module sine_frame_seq
    import sine_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned DAYNIGHT_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pause,
    input  logic       frame_start,
`ifdef SINE_SCROLL_REVERSE_EN
    input  logic       scroll_dir,
`endif
    output logic       drawing,
    output logic [5:0] scroll_pos,
    output logic       daynight
);

    localparam logic [3:0] STEP_LAST  = 4'(FRAMES_PER_STEP - 1);
    localparam logic [9:0] FRAME_LAST = 10'(DAYNIGHT_PERIOD - 1);

    sine_state_t state, next_state;
    logic [3:0]  step_cnt;
    logic [9:0]  frame_cnt;
    logic        advance_c;
    logic        step_dec_c;

`ifdef SINE_SCROLL_REVERSE_EN
    assign step_dec_c = scroll_dir;
`else
    assign step_dec_c = 1'b0;
`endif

    // Counters advance on the pre-transition state, so a RUN->PAUSED edge still steps once.
    assign advance_c = ena && frame_start && (state == RUN);

    // Next-state: ena low drops to IDLE at once; everything else waits for a frame boundary.
    always_comb begin
        next_state = state;
        if (!ena) begin
            next_state = IDLE;
        end else if (frame_start) begin
            next_state = pause ? PAUSED : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            drawing <= 1'b0;
        end else begin
            state   <= next_state;
            drawing <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt   <= 4'd0;
            frame_cnt  <= 10'd0;
            scroll_pos <= 6'd0;
            daynight   <= 1'b0;
        end else if (advance_c) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt   <= 4'd0;
                scroll_pos <= step_dec_c ? scroll_pos - 6'd1 : scroll_pos + 6'd1;
            end else begin
                step_cnt <= step_cnt + 4'd1;
            end
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= 10'd0;
                daynight  <= ~daynight;
            end else begin
                frame_cnt <= frame_cnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/sine_scroll_ctrl.sv
// Quarter-sine layer controller: pixel-to-cell mapping with scroll, plus a 2-stage colour pipeline.
// Optional scroll_dir port and reverse scrolling are enabled with SINE_SCROLL_REVERSE_EN.
module sine_scroll_ctrl
    import sine_pkg::*;
#(
    parameter int unsigned SCALE_SHIFT     = 3,
    parameter int unsigned Y_TOP           = 128,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned DAYNIGHT_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pause,
    input  logic       frame_start,
`ifdef SINE_SCROLL_REVERSE_EN
    input  logic       scroll_dir,
`endif
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic [5:0] sine_rgb,
    output logic [5:0] sine_x,
    output logic [4:0] sine_y,
    output logic       daynight,
    output logic [5:0] rgb_out,
    output logic [5:0] scroll_pos
);

    localparam logic [9:0] Y_TOP_W    = 10'(Y_TOP);
    localparam logic [9:0] ROW_LAST_W = 10'(SINE_BAND_ROWS - 1);

    logic       drawing;
    logic       de1;
    logic [9:0] hcell_c;
    logic [9:0] row_c;
    logic       in_band_c;

    sine_frame_seq #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .DAYNIGHT_PERIOD (DAYNIGHT_PERIOD)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .pause       (pause),
        .frame_start (frame_start),
`ifdef SINE_SCROLL_REVERSE_EN
        .scroll_dir  (scroll_dir),
`endif
        .drawing     (drawing),
        .scroll_pos  (scroll_pos),
        .daynight    (daynight)
    );

    // Row is computed in 10 bits; rows above the band wrap high and are caught by the vpos test.
    assign hcell_c   = hpos >> SCALE_SHIFT;
    assign row_c     = (vpos - Y_TOP_W) >> SCALE_SHIFT;
    assign in_band_c = (vpos >= Y_TOP_W) && (row_c <= ROW_LAST_W);

    // Stage 1: cell coordinates to the sine layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sine_x <= 6'd0;
            sine_y <= SINE_Y_BLANK;
            de1    <= 1'b0;
        end else begin
            sine_x <= 6'(hcell_c) + scroll_pos;
            sine_y <= in_band_c ? 5'(row_c) : SINE_Y_BLANK;
            de1    <= display_on;
        end
    end

    // Stage 2: capture the layer colour, blanked outside active video or when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= RGB_BLACK;
        end else begin
            rgb_out <= (de1 && drawing) ? sine_rgb : RGB_BLACK;
        end
    end

endmodule

// File: tb/tb_sine_scroll_ctrl.sv
// Directed self-checking bench for sine_scroll_ctrl (FRAMES_PER_STEP=2, DAYNIGHT_PERIOD=4).
module tb_sine_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pause;
    logic       frame_start;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic [5:0] sine_rgb;
    logic [5:0] sine_x;
    logic [4:0] sine_y;
    logic       daynight;
    logic [5:0] rgb_out;
    logic [5:0] scroll_pos;
`ifdef SINE_SCROLL_REVERSE_EN
    logic       scroll_dir = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in sine layer: colour is a simple function of the requested cell.
    assign sine_rgb = sine_x ^ {1'b0, sine_y};

    sine_scroll_ctrl #(
        .SCALE_SHIFT     (3),
        .Y_TOP           (128),
        .FRAMES_PER_STEP (2),
        .DAYNIGHT_PERIOD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .pause       (pause),
        .frame_start (frame_start),
`ifdef SINE_SCROLL_REVERSE_EN
        .scroll_dir  (scroll_dir),
`endif
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .sine_rgb    (sine_rgb),
        .sine_x      (sine_x),
        .sine_y      (sine_y),
        .daynight    (daynight),
        .rgb_out     (rgb_out),
        .scroll_pos  (scroll_pos)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick(1);
            frame_start = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; pause = 1'b0; frame_start = 1'b0;
        hpos = '0; vpos = '0; display_on = 1'b0;
        tick(3);
        check("reset_sine_x",   10'(sine_x),     10'd0);
        check("reset_sine_y",   10'(sine_y),     10'd31);
        check("reset_rgb",      10'(rgb_out),    10'd0);
        check("reset_scroll",   10'(scroll_pos), 10'd0);
        check("reset_daynight", 10'(daynight),   10'd0);

        rst_n = 1'b1;
        ena   = 1'b1;
        tick(2);
        frames(1);
        check("run_entry_no_step", 10'(scroll_pos), 10'd0);

        hpos = 10'd80; vpos = 10'd128; display_on = 1'b1;
        tick(1);
        check("map_sine_x", 10'(sine_x), 10'd10);
        check("map_sine_y", 10'(sine_y), 10'd0);
        tick(1);
        check("rgb_latency2", 10'(rgb_out), 10'd10);

        vpos = 10'd127; tick(1);
        check("above_band_y", 10'(sine_y), 10'd31);
        vpos = 10'd304; tick(1);
        check("row22_y", 10'(sine_y), 10'd31);
        vpos = 10'd303; tick(1);
        check("row21_y", 10'(sine_y), 10'd21);
        display_on = 1'b0; tick(2);
        check("blank_rgb", 10'(rgb_out), 10'd0);

        frames(3);
        check("scroll_after3", 10'(scroll_pos), 10'd1);
        check("dn_after3",     10'(daynight),   10'd0);
        frames(1);
        check("dn_toggle4",    10'(daynight),   10'd1);
        frames(4);
        check("dn_toggle8",    10'(daynight),   10'd0);
        frames(56);
        check("scroll_after64", 10'(scroll_pos), 10'd32);
        frames(62);
        check("scroll_63",      10'(scroll_pos), 10'd63);
        check("dn_after126",    10'(daynight),   10'd1);
        frames(2);
        check("scroll_wrap0",   10'(scroll_pos), 10'd0);
        frames(10);
        check("scroll_5",       10'(scroll_pos), 10'd5);

        hpos = 10'd504; vpos = 10'd128; tick(1);
        check("sine_x_wrap", 10'(sine_x), 10'd4);

        frames(1);
        pause = 1'b1; tick(3);
        frames(1);
        check("pause_edge_scroll", 10'(scroll_pos), 10'd6);
        check("pause_edge_dn",     10'(daynight),   10'd1);
        frames(10);
        check("paused_scroll", 10'(scroll_pos), 10'd6);
        check("paused_dn",     10'(daynight),   10'd1);
        pause = 1'b0;
        frames(1);
        check("resume_no_step", 10'(scroll_pos), 10'd6);

        hpos = 10'd80; vpos = 10'd128; display_on = 1'b1;
        tick(2);
        check("run_rgb", 10'(rgb_out), 10'd16);
        ena = 1'b0;
        tick(2);
        check("ena_off_rgb", 10'(rgb_out), 10'd0);
        frames(3);
        check("idle_hold_scroll", 10'(scroll_pos), 10'd6);
        ena = 1'b1;
        frames(1);
        check("reen_scroll", 10'(scroll_pos), 10'd6);
        check("reen_dn",     10'(daynight),   10'd1);
        tick(2);
        check("reen_rgb",    10'(rgb_out),    10'd16);

        rst_n = 1'b0;
        #1;
        check("async_sine_x",   10'(sine_x),     10'd0);
        check("async_sine_y",   10'(sine_y),     10'd31);
        check("async_rgb",      10'(rgb_out),    10'd0);
        check("async_scroll",   10'(scroll_pos), 10'd0);
        check("async_daynight", 10'(daynight),   10'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sine_scroll_ctrl.md
Name: sine_scroll_ctrl

Overview:
- Sequencer for the quarter-sine colour layer.
- Converts VGA pixel coordinates into scaled cell coordinates x[5:0] / y[4:0] and applies a per-frame horizontal scroll.
- Runs a run/pause/idle state machine and toggles day/night every N frames.
- Registers the layer's combinational colour into a 2-stage pixel pipeline. Sits between the VGA timing generator and the output mux.

Parameters:
- SCALE_SHIFT, 3, log2 of pixels per cell (8x8 px cells).
- Y_TOP, 128, first vpos of the wave band.
- FRAMES_PER_STEP, 2, frames between scroll increments (1..15).
- DAYNIGHT_PERIOD, 256, frames between day/night toggles (2..1024).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; low forces IDLE
- pause  in  1  freeze scroll/day-night while still drawing
- frame_start  in  1  one-cycle strobe at vsync start
- hpos  in  10  current pixel column
- vpos  in  10  current pixel row
- display_on  in  1  active-video flag aligned with hpos/vpos
- sine_rgb  in  6  colour returned by the sine layer for sine_x/sine_y
- sine_x  out  6  cell column to the sine layer
- sine_y  out  5  cell row to the sine layer
- daynight  out  1  palette select to the sine layer
- rgb_out  out  6  RRGGBB pixel, 2-cycle latency from hpos/vpos
- scroll_pos  out  6  current scroll offset, debug/status

Behaviour:
- Reset: state=IDLE; scroll_pos=0; frame_cnt=0; step_cnt=0; daynight=0; sine_x=0; sine_y=31; rgb_out=0; pipeline valid flags=0.
- Stage 1, registered every cycle:
  - sine_x = ((hpos >> SCALE_SHIFT) + scroll_pos) mod 64.
  - row = (vpos - Y_TOP) >> SCALE_SHIFT, computed in 10 bits.
  - If vpos < Y_TOP or row > 21, sine_y = 31 (layer outputs background); otherwise sine_y = row[4:0].
  - de1 = display_on.
- Stage 2, registered: rgb_out = (de1 && state != IDLE) ? sine_rgb : 6'b000000.
- Latency: rgb_out reflects the hpos/vpos presented 2 cycles earlier. The VGA path must delay sync by 2.
- FSM states: IDLE, RUN, PAUSED. Transitions are evaluated only on frame_start cycles, so a frame never tears.
  - IDLE -> RUN when ena=1 and pause=0.
  - IDLE -> PAUSED when ena=1 and pause=1.
  - RUN <-> PAUSED follows pause.
  - Any state -> IDLE when ena=0. ena=0 forces rgb_out=0 within 2 cycles, without waiting for frame_start.
- RUN, on each frame_start:
  - step_cnt increments. When it reaches FRAMES_PER_STEP-1 it clears and scroll_pos increments, wrapping 63->0.
  - frame_cnt increments. When it reaches DAYNIGHT_PERIOD-1 it clears and daynight toggles.
- PAUSED and IDLE: all counters and daynight hold. Entering IDLE does not clear scroll_pos or daynight. Only rst_n clears them.
- Simultaneous events:
  - frame_start with ena=0 goes to IDLE; no counter update on that edge.
  - The counter update uses the state before the transition. A RUN->PAUSED edge still advances once. A PAUSED->RUN edge does not advance.
- Counters: frame_cnt is 10 bits, step_cnt is 4 bits.
- sine_x wrap: sums at 64 or above drop bit 6. With hpos up to 799, hpos>>3 reaches 99, and 99 mod 64 is used.
- Reset mid-frame: all state clears asynchronously. The first valid update is the next frame_start after rst_n rises.

Optional Feature:
- Macro: SINE_SCROLL_REVERSE_EN.
- Defined: adds input port scroll_dir (1 bit). scroll_dir=1 decrements scroll_pos (0->63 wrap) instead of incrementing. It is sampled on the frame_start edge that performs the step.
- Undefined: the port is absent and scrolling is always increment.

Decomposition:
- Package sine_pkg holds:
  - FSM state enum (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2).
  - SINE_BAND_ROWS=22.
  - SINE_Y_BLANK=5'd31.
  - RGB_BLACK=6'b000000.
- Sub-module sine_frame_seq: the FSM plus step_cnt, frame_cnt, scroll_pos and daynight.
- The top instantiates it next to the two-stage pixel pipeline.

Test Plan:
- Reset, ena=1, pause=0, one frame_start -> state RUN. Then hpos=80, vpos=128, display_on=1 -> sine_x=10, sine_y=0 one cycle later; rgb_out=sine_rgb two cycles later.
- vpos=127 and vpos=304 (row 22) -> sine_y=31. vpos=303 -> sine_y=21.
- RUN with FRAMES_PER_STEP=2 -> scroll_pos=1 after 2 frame_starts (excluding the first, IDLE->RUN edge) and 32 after 64. Step from 63 wraps to 0. hpos=504 with scroll 5 -> sine_x=4.
- DAYNIGHT_PERIOD=4 -> daynight toggles on the 4th and 8th RUN frame_start. Raise pause mid-frame -> toggling stops after the next frame_start; the counters are unchanged over 10 frames.
- ena dropped mid-line -> rgb_out=0 within 2 cycles, state IDLE. Re-enable -> scroll_pos and daynight keep their earlier values.
- Assert rst_n low mid-frame -> all outputs are at reset values immediately, without a clock edge.
